// File: rtl/genius_pkg.sv
// Shared constants for the Genius game datapath: symbol width, colour
// encodings with their one-hot LED patterns, and the playback FSM encoding.
package genius_pkg;

   localparam int SYM_W = 2;

   // Colour codes as stored in the sequence register
   localparam logic [1:0] COL_GREEN  = 2'd0;
   localparam logic [1:0] COL_RED    = 2'd1;
   localparam logic [1:0] COL_YELLOW = 2'd2;
   localparam logic [1:0] COL_BLUE   = 2'd3;

   // LED patterns, bit position matches the KEY the player presses
   localparam logic [3:0] LED_GREEN  = 4'b0001;
   localparam logic [3:0] LED_RED    = 4'b0010;
   localparam logic [3:0] LED_YELLOW = 4'b0100;
   localparam logic [3:0] LED_BLUE   = 4'b1000;

   // Playback FSM encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ON   = 2'd1;
   localparam logic [1:0] ST_OFF  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // Colour code to one-hot LED pattern
   function automatic logic [3:0] sym_to_led(input logic [SYM_W-1:0] sym);
      logic [3:0] led;
      led = 4'b0000;
      case (sym)
         COL_GREEN:  led = LED_GREEN;
         COL_RED:    led = LED_RED;
         COL_YELLOW: led = LED_YELLOW;
         COL_BLUE:   led = LED_BLUE;
         default:    led = 4'b0000;
      endcase
      return led;
   endfunction

endpackage

// File: rtl/genius_interval_timer.sv
// Loadable down-counter used for both the lit and dark intervals.
// Loading value N gives an expiry N+1 cycles later; the counter rests at 0.
module genius_interval_timer #(
   parameter int TW = 2
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          load_i,
   input  logic [TW-1:0] value_i,
   output logic          expired_o
);

   logic [TW-1:0] count_q;

   // Count down to zero and hold; a load always wins
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= value_i;
      end else if (count_q != '0) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign expired_o = (count_q == '0);

endmodule

// File: rtl/genius_seq_player.sv
// Plays the latched Genius colour sequence on the four LEDs, one symbol per
// lit/dark interval, and pulses end_fpga_o when the round is complete.
// Optional feature macro: GENIUS_SPEEDUP_EN halves the lit time once the
// round reaches half the maximum sequence length.
// Handshake: start_i is a single-cycle request taken only while busy_o is
// low; end_fpga_o is a one-cycle pulse coinciding with the last busy cycle.
module genius_seq_player #(
   parameter int SEQ_LEN    = 16,
   parameter int SYM_W      = genius_pkg::SYM_W,
   parameter int ON_CYCLES  = 25_000_000,
   parameter int OFF_CYCLES = 12_500_000,
   parameter int IDX_W      = $clog2(SEQ_LEN) + 1
) (
   input  logic                     clock_50,
   input  logic                     reset_n,
   input  logic                     start_i,
   input  logic [IDX_W-1:0]         round_i,
   input  logic [SEQ_LEN*SYM_W-1:0] seq_i,
   output logic [3:0]               leds_o,
   output logic [IDX_W-1:0]         idx_o,
   output logic                     busy_o,
   output logic                     end_fpga_o,
   output logic [1:0]               dbg_state_o
);

   import genius_pkg::*;

   localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [TW-1:0]    ON_LOAD   = TW'(ON_CYCLES - 1);
   localparam logic [TW-1:0]    OFF_LOAD  = TW'(OFF_CYCLES - 1);
   localparam logic [IDX_W-1:0] MAX_ROUND = IDX_W'(SEQ_LEN);

   logic [1:0]               state_q, state_d;
   logic [SEQ_LEN*SYM_W-1:0] seq_q, seq_d;
   logic [IDX_W-1:0]         round_q, round_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [3:0]               leds_q, leds_d;
   logic                     busy_q, busy_d;
   logic                     end_q, end_d;

   logic                     tmr_load;
   logic [TW-1:0]            tmr_value;
   logic                     tmr_expired;

   logic [IDX_W-1:0]         round_clamp;
   logic [IDX_W-1:0]         idx_inc;
   logic [IDX_W-2:0]         sel_next;
   logic [SYM_W-1:0]         sym_next;
   logic [TW-1:0]            on_load_start;
   logic [TW-1:0]            on_load_run;

   assign round_clamp = (round_i > MAX_ROUND) ? MAX_ROUND : round_i;
   assign idx_inc     = idx_q + 1'b1;
   // idx_inc only reaches SEQ_LEN when going to DONE, so wrapping the select is safe
   assign sel_next    = idx_inc[IDX_W-2:0];
   assign sym_next    = seq_q[sel_next*SYM_W +: SYM_W];

`ifdef GENIUS_SPEEDUP_EN
   localparam logic [TW-1:0]    ON_FAST_LOAD = TW'((ON_CYCLES >> 1) - 1);
   localparam logic [IDX_W-1:0] FAST_ROUND   = IDX_W'(SEQ_LEN / 2);
   assign on_load_start = (round_clamp >= FAST_ROUND) ? ON_FAST_LOAD : ON_LOAD;
   assign on_load_run   = (round_q >= FAST_ROUND) ? ON_FAST_LOAD : ON_LOAD;
`else
   assign on_load_start = ON_LOAD;
   assign on_load_run   = ON_LOAD;
`endif

   genius_interval_timer #(.TW(TW)) u_timer (
      .clk_i     (clock_50),
      .rst_ni    (reset_n),
      .load_i    (tmr_load),
      .value_i   (tmr_value),
      .expired_o (tmr_expired)
   );

   // Next-state logic: LED pattern is decided one cycle early so it is registered
   always_comb begin
      state_d   = state_q;
      seq_d     = seq_q;
      round_d   = round_q;
      idx_d     = idx_q;
      leds_d    = leds_q;
      end_d     = 1'b0;
      tmr_load  = 1'b0;
      tmr_value = OFF_LOAD;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               seq_d     = seq_i;
               round_d   = round_clamp;
               idx_d     = '0;
               tmr_load  = 1'b1;
               tmr_value = on_load_start;
               if (round_i == '0) begin
                  state_d = ST_DONE;
                  end_d   = 1'b1;
                  leds_d  = 4'b0000;
               end else begin
                  state_d = ST_ON;
                  leds_d  = sym_to_led(seq_i[SYM_W-1:0]);
               end
            end
         end
         ST_ON: begin
            if (tmr_expired) begin
               state_d   = ST_OFF;
               leds_d    = 4'b0000;
               tmr_load  = 1'b1;
               tmr_value = OFF_LOAD;
            end
         end
         ST_OFF: begin
            if (tmr_expired) begin
               idx_d = idx_inc;
               if (idx_inc == round_q) begin
                  state_d = ST_DONE;
                  end_d   = 1'b1;
               end else begin
                  state_d   = ST_ON;
                  leds_d    = sym_to_led(sym_next);
                  tmr_load  = 1'b1;
                  tmr_value = on_load_run;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers, cleared asynchronously
   always_ff @(posedge clock_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         seq_q   <= '0;
         round_q <= '0;
         idx_q   <= '0;
         leds_q  <= '0;
         busy_q  <= 1'b0;
         end_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         seq_q   <= seq_d;
         round_q <= round_d;
         idx_q   <= idx_d;
         leds_q  <= leds_d;
         busy_q  <= busy_d;
         end_q   <= end_d;
      end
   end

   assign leds_o      = leds_q;
   assign idx_o       = idx_q;
   assign busy_o      = busy_q;
   assign end_fpga_o  = end_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_genius_seq_player.sv
// Bench for genius_seq_player with SEQ_LEN=8, ON_CYCLES=4, OFF_CYCLES=2.
// Honours GENIUS_SPEEDUP_EN when the build defines it.
module tb_genius_seq_player;

   localparam int SEQ_LEN    = 8;
   localparam int SYM_W      = 2;
   localparam int ON_CYCLES  = 4;
   localparam int OFF_CYCLES = 2;
   localparam int IDX_W      = 4;
   localparam int SW         = SEQ_LEN * SYM_W;

`ifdef GENIUS_SPEEDUP_EN
   localparam int T3_END      = 33;
   localparam int T3_LAST     = 29;
   localparam int T6_END      = 17;
   localparam logic [3:0] T6_C3 = 4'b0000;
   localparam logic [3:0] T6_C5 = 4'b0010;
`else
   localparam int T3_END      = 49;
   localparam int T3_LAST     = 43;
   localparam int T6_END      = 25;
   localparam logic [3:0] T6_C3 = 4'b0001;
   localparam logic [3:0] T6_C5 = 4'b0000;
`endif

   logic             clock_50 = 1'b0;
   logic             reset_n  = 1'b1;
   logic             start_i  = 1'b0;
   logic [IDX_W-1:0] round_i  = '0;
   logic [SW-1:0]    seq_i    = '0;
   logic [3:0]       leds_o;
   logic [IDX_W-1:0] idx_o;
   logic             busy_o;
   logic             end_fpga_o;
   logic [1:0]       dbg_state_o;

   genius_seq_player #(
      .SEQ_LEN(SEQ_LEN), .SYM_W(SYM_W), .ON_CYCLES(ON_CYCLES),
      .OFF_CYCLES(OFF_CYCLES), .IDX_W(IDX_W)
   ) dut (
      .clock_50(clock_50), .reset_n(reset_n), .start_i(start_i),
      .round_i(round_i), .seq_i(seq_i), .leds_o(leds_o), .idx_o(idx_o),
      .busy_o(busy_o), .end_fpga_o(end_fpga_o), .dbg_state_o(dbg_state_o)
   );

   // Clock and watchdog
   always #5 clock_50 = ~clock_50;

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   int n_tests = 0;
   int n_fail  = 0;
   int edge_n  = 0;
   int t0      = 0;
   bit chk_en  = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, edge_n);
      end
   endtask

   // Playback model: a play starting with start sampled at the end of cycle
   // m_t lights symbol j during cycles m_t+1+j*P .. m_t+j*P+on, P=on+off,
   // pulses end at m_t+1+n*P, and is idle afterwards with idx = n.
   bit            m_valid = 1'b0;
   int            m_t, m_n, m_on;
   logic [SW-1:0] m_seq;

   function automatic void model_at(input int e, output logic [3:0] leds,
                                    output logic [IDX_W-1:0] idx,
                                    output logic busy, output logic endp);
      int k, p, j, r;
      leds = 4'b0000; idx = '0; busy = 1'b0; endp = 1'b0;
      if (!m_valid) return;
      k   = e - m_t;
      p   = m_on + OFF_CYCLES;
      idx = IDX_W'(m_n);
      if (k >= 1 && k <= m_n * p) begin
         j    = (k - 1) / p;
         r    = (k - 1) % p;
         busy = 1'b1;
         idx  = IDX_W'(j);
         if (r < m_on) leds = 4'b0001 << m_seq[j*SYM_W +: SYM_W];
      end else if (k == m_n * p + 1) begin
         busy = 1'b1;
         endp = 1'b1;
      end
   endfunction

   always @(negedge reset_n) m_valid = 1'b0;

   logic [3:0]       e_leds;
   logic [IDX_W-1:0] e_idx;
   logic             e_busy, e_end;

   // Model update on each edge, then per-cycle compare 1 time unit later
   always @(posedge clock_50) begin
      edge_n = edge_n + 1;
      if (reset_n && start_i) begin
         model_at(edge_n - 1, e_leds, e_idx, e_busy, e_end);
         if (!e_busy) begin
            m_valid = 1'b1;
            m_t     = edge_n - 1;
            m_n     = (int'(round_i) > SEQ_LEN) ? SEQ_LEN : int'(round_i);
            m_seq   = seq_i;
            m_on    = ON_CYCLES;
`ifdef GENIUS_SPEEDUP_EN
            if (m_n >= SEQ_LEN / 2) m_on = ON_CYCLES / 2;
`endif
         end
      end
      #1;
      if (chk_en) begin
         model_at(edge_n, e_leds, e_idx, e_busy, e_end);
         check("model_leds", 32'(leds_o), 32'(e_leds));
         check("model_idx",  32'(idx_o),  32'(e_idx));
         check("model_busy", 32'(busy_o), 32'(e_busy));
         check("model_end",  32'(end_fpga_o), 32'(e_end));
      end
   end

   // Driver tasks: callers sit at a negedge; cycle c is the one after start's edge + c-1
   task automatic wait_cyc(input int c);
      while (edge_n < t0 + c) @(negedge clock_50);
   endtask

   task automatic start_play(input int r, input logic [SW-1:0] s);
      start_i = 1'b1;
      round_i = r[IDX_W-1:0];
      seq_i   = s;
      t0      = edge_n;
      @(negedge clock_50);
      start_i = 1'b0;
   endtask

   initial begin
      // Reset
      #2 reset_n = 1'b0;
      #1;
      check("reset_leds", 32'(leds_o), 32'h0);
      check("reset_busy", 32'(busy_o), 32'h0);
      check("reset_idx",  32'(idx_o),  32'h0);
      check("reset_end",  32'(end_fpga_o), 32'h0);
      repeat (3) @(negedge clock_50);
      reset_n = 1'b1;
      chk_en  = 1'b1;
      @(negedge clock_50);

      // T1: round 3, sequence {2,0,3}; start in the DONE cycle is ignored
      start_play(3, 16'h0032);
      wait_cyc(1);  check("t1_c1_leds", 32'(leds_o), 32'h4);
                    check("t1_c1_busy", 32'(busy_o), 32'h1);
      wait_cyc(4);  check("t1_c4_leds", 32'(leds_o), 32'h4);
      wait_cyc(5);  check("t1_c5_leds", 32'(leds_o), 32'h0);
      wait_cyc(7);  check("t1_c7_leds", 32'(leds_o), 32'h1);
                    check("t1_c7_idx",  32'(idx_o),  32'h1);
      wait_cyc(13); check("t1_c13_leds", 32'(leds_o), 32'h8);
      wait_cyc(18); check("t1_c18_end", 32'(end_fpga_o), 32'h0);
      wait_cyc(19); check("t1_c19_end", 32'(end_fpga_o), 32'h1);
                    check("t1_c19_busy", 32'(busy_o), 32'h1);
      start_i = 1'b1; round_i = 4'd2;
      wait_cyc(20); start_i = 1'b0;
                    check("t1_c20_busy", 32'(busy_o), 32'h0);
                    check("t1_c20_end", 32'(end_fpga_o), 32'h0);

      // T2: round 0, started in the first idle cycle after the pulse
      start_play(0, 16'hFFFF);
      wait_cyc(1);  check("t2_c1_end", 32'(end_fpga_o), 32'h1);
                    check("t2_c1_leds", 32'(leds_o), 32'h0);
      wait_cyc(2);  check("t2_c2_busy", 32'(busy_o), 32'h0);

      // T3: round 12 clamps to 8
      wait_cyc(3);
      start_play(12, 16'hE41B);
      wait_cyc(1);          check("t3_c1_leds", 32'(leds_o), 32'h8);
      wait_cyc(T3_LAST);    check("t3_last_leds", 32'(leds_o), 32'h8);
      wait_cyc(T3_END - 1); check("t3_pre_end", 32'(end_fpga_o), 32'h0);
      wait_cyc(T3_END);     check("t3_end", 32'(end_fpga_o), 32'h1);
                            check("t3_idx", 32'(idx_o), 32'h8);

      // T4: latched copies only; second start ignored
      wait_cyc(T3_END + 1);
      start_play(2, 16'h0009);
      wait_cyc(2);  seq_i = 16'h00FF;
      wait_cyc(4);  start_i = 1'b1; round_i = 4'd5;
      wait_cyc(5);  start_i = 1'b0;
      wait_cyc(7);  check("t4_c7_leds", 32'(leds_o), 32'h4);
      wait_cyc(13); check("t4_c13_end", 32'(end_fpga_o), 32'h1);
      wait_cyc(14); check("t4_c14_busy", 32'(busy_o), 32'h0);

      // T5: asynchronous reset mid-ON, then a clean replay
      wait_cyc(15);
      start_play(3, 16'h0032);
      wait_cyc(8);  check("t5_c8_leds", 32'(leds_o), 32'h1);
      reset_n = 1'b0;
      #1;
      check("t5_rst_leds", 32'(leds_o), 32'h0);
      check("t5_rst_busy", 32'(busy_o), 32'h0);
      check("t5_rst_idx",  32'(idx_o),  32'h0);
      wait_cyc(12); reset_n = 1'b1;
      wait_cyc(19);
      start_play(2, 16'h0006);
      wait_cyc(1);  check("t5b_c1_idx", 32'(idx_o), 32'h0);
                    check("t5b_c1_leds", 32'(leds_o), 32'h4);
      wait_cyc(7);  check("t5b_c7_leds", 32'(leds_o), 32'h2);
      wait_cyc(13); check("t5b_c13_end", 32'(end_fpga_o), 32'h1);

      // T6: round 4 (speedup threshold) then round 3
      wait_cyc(15);
      start_play(4, 16'h00E4);
      wait_cyc(1);      check("t6_c1_leds", 32'(leds_o), 32'h1);
      wait_cyc(3);      check("t6_c3_leds", 32'(leds_o), 32'(T6_C3));
      wait_cyc(5);      check("t6_c5_leds", 32'(leds_o), 32'(T6_C5));
      wait_cyc(T6_END); check("t6_end", 32'(end_fpga_o), 32'h1);
      wait_cyc(T6_END + 2);
      start_play(3, 16'h0032);
      wait_cyc(4);  check("t6b_c4_leds", 32'(leds_o), 32'h4);
      wait_cyc(19); check("t6b_c19_end", 32'(end_fpga_o), 32'h1);
      wait_cyc(22);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/genius_seq_player.md
# genius_seq_player

Plays the stored Genius colour sequence to the player on the four LEDs, one symbol at a time with fixed on/off intervals. It is the FPGA-to-player counterpart of the player-input capture path: the datapath supplies the sequence register and the current round, and the block returns `end_fpga` to the control FSM when playback is complete. It sits inside the datapath, driving `LEDR[3:0]`.

## Interface

Parameters:
- `SEQ_LEN`, 16: maximum sequence length (rounds), power of two.
- `SYM_W`, 2: bits per symbol, giving 4 colours mapped to KEY[3:0].
- `ON_CYCLES`, 25_000_000: clocks each symbol is lit (0.5 s at 50 MHz).
- `OFF_CYCLES`, 12_500_000: dark gap in clocks after each symbol.
- `IDX_W`, $clog2(SEQ_LEN)+1: width of the round and index fields.

Ports:
- `clock_50`, in, 1: system clock, rising edge.
- `reset_n`, in, 1: asynchronous reset, active low.
- `start_i`, in, 1: single-cycle playback request.
- `round_i`, in, IDX_W: number of symbols to play; latched on start.
- `seq_i`, in, SEQ_LEN*SYM_W: flat sequence with symbol k at bits [k*SYM_W +: SYM_W]; latched on start.
- `leds_o`, out, 4: one-hot lit colour, or 0 when dark.
- `idx_o`, out, IDX_W: index of the symbol currently being played.
- `busy_o`, out, 1: playback in progress.
- `end_fpga_o`, out, 1: one-cycle completion pulse to the control FSM.

## Operation

- FSM states are IDLE, ON, OFF and DONE.
- **IDLE:**
  - When `start_i` is high, latch `seq_i`, latch the clamped `round_i` (values above SEQ_LEN become SEQ_LEN), clear the index, and load the timer.
  - Go to ON, or to DONE if `round_i` is 0.
- **ON:**
  - `leds_o` is the one-hot decode of symbol[idx]; the timer counts down.
  - When the timer expires, go to OFF and load OFF_CYCLES.
- **OFF:**
  - `leds_o` is 0.
  - When the timer expires, increment idx.
  - If idx+1 equals the latched round, go to DONE. Otherwise go to ON and load the on-time.
- **DONE:** assert `end_fpga_o` for one cycle, then return to IDLE.
- `busy_o` is high in ON, OFF and DONE.
- `start_i` is ignored while busy; there is no restart mid-play.
- Playback uses only the latched copies, so changes on `seq_i` or `round_i` during playback have no effect.
- Timer width is $clog2(max(ON_CYCLES, OFF_CYCLES)). It reloads with value−1 and expires at 0.
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - `leds_o`, `idx_o`, `busy_o` and `end_fpga_o` all go to 0.
  - The latched sequence, latched round and timer are cleared.

## Timing

- `start_i` sampled high at edge t: the first symbol is lit from cycle t+1 for ON_CYCLES cycles, then dark for OFF_CYCLES cycles, repeating for each symbol.
- Round n gives `end_fpga_o` high in cycle t+1+n*(ON_CYCLES+OFF_CYCLES). `busy_o` is high from t+1 through that cycle inclusive.
- `round_i` = 0: `end_fpga_o` goes high at t+1 and `leds_o` never lights.
- `start_i` in the same cycle as the DONE pulse is ignored. A new start is accepted from the first IDLE cycle after the pulse.
- Outputs are registered, with no combinational path from inputs to outputs.

## Configuration

- Macro: `GENIUS_SPEEDUP_EN`.
- **Defined:** when the latched round is at least SEQ_LEN/2, the on-time is ON_CYCLES/2 (integer shift). OFF_CYCLES is unchanged.
- **Not defined:** the on-time is always ON_CYCLES. The speedup logic is absent.

## Structure

- Shared package `genius_pkg` holds:
  - Colour encodings GREEN=0, RED=1, YELLOW=2, BLUE=3 and their one-hot LED constants.
  - The SYM_W constant.
  - The player FSM state encoding.
- Sub-module `genius_interval_timer`: loadable down-counter with `load_i`, `value_i` and an `expired_o` pulse, used for both the ON and OFF intervals.

## Test plan

Bench parameters are SEQ_LEN=8, ON_CYCLES=4, OFF_CYCLES=2, with start at cycle 0.

1. **Round 3, sequence {2,0,3}:**
   - `leds_o` is 0100 in cycles 1–4, 0000 in 5–6, 0001 in 7–10, 0000 in 11–12, 1000 in 13–16, 0000 in 17–18.
   - `end_fpga_o` pulses at 19.
   - `busy_o` is high for cycles 1–19.
2. **Round 0:** `end_fpga_o` pulses at cycle 1, `leds_o` stays 0, and `busy_o` is high for cycle 1 only.
3. **Round 12 (clamped):** 8 symbols are played and `end_fpga_o` pulses at cycle 49.
4. **Second start at cycle 5 and `seq_i` changed at cycle 3 (round 2):** the second start is ignored, the original latched symbols are played, and `end_fpga_o` pulses at 13.
5. **`reset_n` low at cycle 8 during ON:** all outputs go to 0 immediately. After release, start at cycle 20 plays normally from index 0.
6. **`GENIUS_SPEEDUP_EN` defined, round 4:** symbols are lit for 2 cycles each and `end_fpga_o` pulses at cycle 17. With round 3, the on-time stays 4 cycles.
